// File: rtl/wb_b3_arbiter.sv
// wb_b3_arbiter
//   Round-robin arbiter that shares one Wishbone B3 slave port among
//   NUM_MASTERS masters. A master owns the bus for as long as it holds
//   m_cyc, so whole bus cycles, including bursts of transfers, are granted.
//
// Ports
//   clock, reset     bus clock; asynchronous active-high reset
//   m_cyc/m_stb/m_we per-master request, strobe and write enable
//   m_adr/m_dat_w/m_sel  packed per-master address, write data, byte select
//                    (master i at [i*W +: W])
//   m_dat_r          slave read data, broadcast to every master
//   m_ack/m_err/m_rty  per-master responses, only the owner's bit can be set
//   s_*              single slave port driven by the current owner
//   grant            one-hot current owner, zero when idle
//   busy             high while a master owns the bus
//
// Optional feature
//   WB_ARB_TIMEOUT_EN  when defined, a stalled strobe is terminated with a
//                      one-cycle m_err after TIMEOUT_CYCLES stalled cycles.
//                      When undefined a stalled slave holds the bus forever.

module wb_b3_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SELECT_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_MASTERS-1:0]              m_cyc,
    input  logic [NUM_MASTERS-1:0]              m_stb,
    input  logic [NUM_MASTERS-1:0]              m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_w,
    input  logic [NUM_MASTERS*SELECT_WIDTH-1:0] m_sel,
    output logic [DATA_WIDTH-1:0]               m_dat_r,
    output logic [NUM_MASTERS-1:0]              m_ack,
    output logic [NUM_MASTERS-1:0]              m_err,
    output logic [NUM_MASTERS-1:0]              m_rty,
    output logic                                s_cyc,
    output logic                                s_stb,
    output logic                                s_we,
    output logic [ADDR_WIDTH-1:0]               s_adr,
    output logic [DATA_WIDTH-1:0]               s_dat_w,
    output logic [SELECT_WIDTH-1:0]             s_sel,
    input  logic [DATA_WIDTH-1:0]               s_dat_r,
    input  logic                                s_ack,
    input  logic                                s_err,
    input  logic                                s_rty,
    output logic [NUM_MASTERS-1:0]              grant,
    output logic                                busy
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state, state_next;
    logic [NUM_MASTERS-1:0] grant_q, grant_next;
    // last_ptr doubles as the owner index while in GRANT
    logic [IDX_W-1:0]       last_ptr, last_ptr_next;
    logic [IDX_W-1:0]       cand;
    logic                   found;
    logic                   timeout_hit;

    // State, grant and round-robin pointer registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant_q  <= '0;
            last_ptr <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state    <= state_next;
            grant_q  <= grant_next;
            last_ptr <= last_ptr_next;
        end
    end

    // Next-state: round-robin search starts just after the previous owner
    always_comb begin
        state_next    = state;
        grant_next    = grant_q;
        last_ptr_next = last_ptr;
        cand          = '0;
        found         = 1'b0;
        case (state)
            IDLE: begin
                for (int k = 1; k <= NUM_MASTERS; k++) begin
                    if (int'(last_ptr) + k >= NUM_MASTERS)
                        cand = IDX_W'(int'(last_ptr) + k - NUM_MASTERS);
                    else
                        cand = IDX_W'(int'(last_ptr) + k);
                    if (!found && m_cyc[cand]) begin
                        found         = 1'b1;
                        state_next    = GRANT;
                        grant_next    = NUM_MASTERS'(1) << cand;
                        last_ptr_next = cand;
                    end
                end
            end
            GRANT: begin
                if (!m_cyc[last_ptr]) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // Outputs: combinational routing from the registered owner
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        m_ack   = '0;
        m_err   = '0;
        m_rty   = '0;
        m_dat_r = s_dat_r;
        grant   = grant_q;
        busy    = (state == GRANT);
        if (state == GRANT) begin
            s_cyc   = m_cyc[last_ptr];
            // A timeout cycle withdraws the strobe so the slave sees no transfer
            s_stb   = m_stb[last_ptr] & ~timeout_hit;
            s_we    = m_we[last_ptr];
            s_adr   = m_adr[int'(last_ptr)*ADDR_WIDTH +: ADDR_WIDTH];
            s_dat_w = m_dat_w[int'(last_ptr)*DATA_WIDTH +: DATA_WIDTH];
            s_sel   = m_sel[int'(last_ptr)*SELECT_WIDTH +: SELECT_WIDTH];
            m_ack[last_ptr] = s_ack;
            m_err[last_ptr] = s_err | timeout_hit;
            m_rty[last_ptr] = s_rty;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timeout_count;
    logic          stall;

    // Raw master strobe is used so the stall test does not depend on the
    // gated s_stb it controls.
    assign stall       = (state == GRANT) && m_cyc[last_ptr] && m_stb[last_ptr]
                         && !(s_ack || s_err || s_rty);
    assign timeout_hit = stall && (timeout_count == TW'(TIMEOUT_CYCLES - 1));

    // Stall counter: any response, idle strobe or release restarts it
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            timeout_count <= '0;
        else if (!stall || timeout_hit)
            timeout_count <= '0;
        else
            timeout_count <= timeout_count + TW'(1);
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_wb_b3_arbiter.sv
// tb_wb_b3_arbiter
//   Directed bench for wb_b3_arbiter with four masters and TIMEOUT_CYCLES=8.
//   Inputs change 1 time unit after the rising edge and outputs are sampled
//   there as well, away from the active edge.

module tb_wb_b3_arbiter;

    logic          clock;
    logic          reset;
    logic [3:0]    m_cyc, m_stb, m_we;
    logic [127:0]  m_adr, m_dat_w;
    logic [15:0]   m_sel;
    logic [31:0]   m_dat_r;
    logic [3:0]    m_ack, m_err, m_rty;
    logic          s_cyc, s_stb, s_we;
    logic [31:0]   s_adr, s_dat_w;
    logic [3:0]    s_sel;
    logic [31:0]   s_dat_r;
    logic          s_ack, s_err, s_rty;
    logic [3:0]    grant;
    logic          busy;

    int vectors;
    int miscompares;

    wb_b3_arbiter #(
        .NUM_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .SELECT_WIDTH(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock), .reset(reset),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel),
        .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
        .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty),
        .grant(grant), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task tick;
        @(posedge clock);
        #1;
    endtask

    task drive_master(input int i, input logic cyc, input logic stb, input logic we,
                      input logic [31:0] adr, input logic [31:0] dat);
        m_cyc[i]            = cyc;
        m_stb[i]            = stb;
        m_we[i]             = we;
        m_adr[i*32 +: 32]   = adr;
        m_dat_w[i*32 +: 32] = dat;
        m_sel[i*4 +: 4]     = 4'hF;
    endtask

    task idle_all;
        m_cyc   = '0;
        m_stb   = '0;
        m_we    = '0;
        m_adr   = '0;
        m_dat_w = '0;
        m_sel   = '0;
        s_dat_r = '0;
        s_ack   = 1'b0;
        s_err   = 1'b0;
        s_rty   = 1'b0;
    endtask

    task test_reset;
        reset   = 1'b1;
        idle_all();
        m_cyc   = 4'b1111;
        m_stb   = 4'b1111;
        s_ack   = 1'b1;
        s_dat_r = 32'h12345678;
        tick();
        vectors++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_grant: got grant=%b busy=%b expected 0000/0", grant, busy);
        end
        vectors++;
        if (s_cyc !== 1'b0 || s_stb !== 1'b0 || m_ack !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got s_cyc=%b s_stb=%b m_ack=%b expected 0/0/0000",
                     s_cyc, s_stb, m_ack);
        end
        vectors++;
        if (m_dat_r !== 32'h12345678) begin
            miscompares++;
            $display("[TB] FAIL reset_dat_r: got %h expected 12345678", m_dat_r);
        end
        idle_all();
        reset = 1'b0;
        tick();
        vectors++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_no_request: got grant=%b busy=%b expected 0000/0", grant, busy);
        end
    endtask

    task test_single_request;
        drive_master(1, 1'b1, 1'b1, 1'b1, 32'h4, 32'hA5);
        #1;
        vectors++;
        if (grant !== 4'b0000 || s_cyc !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_latency: got grant=%b s_cyc=%b expected 0000/0", grant, s_cyc);
        end
        tick();
        vectors++;
        if (grant !== 4'b0010 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_grant: got grant=%b busy=%b expected 0010/1", grant, busy);
        end
        vectors++;
        if (s_cyc !== 1'b1 || s_stb !== 1'b1 || s_we !== 1'b1 || s_adr !== 32'h4
            || s_dat_w !== 32'hA5 || s_sel !== 4'hF) begin
            miscompares++;
            $display("[TB] FAIL single_route: got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h expected 1/1/1/4/a5/f",
                     s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel);
        end
        s_ack = 1'b1;
        #1;
        vectors++;
        if (m_ack !== 4'b0010 || m_err !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL single_ack: got m_ack=%b m_err=%b expected 0010/0000", m_ack, m_err);
        end
        drive_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        s_ack = 1'b0;
        tick();
        vectors++;
        if (grant !== 4'b0000 || busy !== 1'b0 || s_cyc !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_release: got grant=%b busy=%b s_cyc=%b expected 0000/0/0",
                     grant, busy, s_cyc);
        end
    endtask

    task test_round_robin;
        logic [3:0] exp_grant;
        reset = 1'b1;
        idle_all();
        m_cyc = 4'b1111;
        m_stb = 4'b1111;
        #2;
        reset = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_grant = 4'b0001 << i;
            vectors++;
            if (grant !== exp_grant) begin
                miscompares++;
                $display("[TB] FAIL rr_grant_%0d: got %b expected %b", i, grant, exp_grant);
            end
            tick();
            vectors++;
            if (grant !== exp_grant) begin
                miscompares++;
                $display("[TB] FAIL rr_hold_%0d: got %b expected %b", i, grant, exp_grant);
            end
            m_cyc[i] = 1'b0;
            m_stb[i] = 1'b0;
            tick();
            vectors++;
            if (grant !== 4'b0000 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL rr_gap_%0d: got grant=%b busy=%b expected 0000/0", i, grant, busy);
            end
            tick();
        end
        vectors++;
        if (grant !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL rr_end_idle: got %b expected 0000", grant);
        end
    endtask

    task test_back_to_back;
        idle_all();
        drive_master(0, 1'b1, 1'b1, 1'b1, 32'h100, 32'h1);
        tick();
        vectors++;
        if (grant !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL b2b_grant0: got %b expected 0001", grant);
        end
        drive_master(2, 1'b1, 1'b1, 1'b0, 32'h200, 32'h2);
        for (int t = 0; t < 3; t++) begin
            m_adr[31:0] = 32'h100 + 32'(t * 4);
            s_ack = 1'b1;
            #1;
            vectors++;
            if (m_ack !== 4'b0001 || grant !== 4'b0001 || s_adr !== 32'h100 + 32'(t * 4)) begin
                miscompares++;
                $display("[TB] FAIL b2b_xfer_%0d: got m_ack=%b grant=%b adr=%h expected 0001/0001/%h",
                         t, m_ack, grant, s_adr, 32'h100 + 32'(t * 4));
            end
            tick();
        end
        s_ack = 1'b0;
        #1;
        vectors++;
        if (grant !== 4'b0001 || m_ack !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL b2b_still_owner: got grant=%b m_ack=%b expected 0001/0000", grant, m_ack);
        end
        // owner drops cyc in the same cycle the ack arrives
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        s_ack    = 1'b1;
        #1;
        vectors++;
        if (m_ack !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL b2b_last_ack: got %b expected 0001", m_ack);
        end
        tick();
        s_ack = 1'b0;
        #1;
        vectors++;
        if (grant !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL b2b_gap: got %b expected 0000", grant);
        end
        tick();
        vectors++;
        if (grant !== 4'b0100 || s_adr !== 32'h200 || s_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_grant2: got grant=%b adr=%h we=%b expected 0100/200/0",
                     grant, s_adr, s_we);
        end
        idle_all();
        tick();
        tick();
    endtask

    task test_reset_mid_transfer;
        idle_all();
        drive_master(3, 1'b1, 1'b1, 1'b1, 32'h300, 32'h3);
        tick();
        vectors++;
        if (grant !== 4'b1000 || s_cyc !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_grant3: got grant=%b s_cyc=%b expected 1000/1", grant, s_cyc);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (grant !== 4'b0000 || s_cyc !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_drop: got grant=%b s_cyc=%b busy=%b expected 0000/0/0",
                     grant, s_cyc, busy);
        end
        drive_master(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        #1;
        reset = 1'b0;
        tick();
        vectors++;
        if (grant !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL mid_after_reset: got %b expected 0001", grant);
        end
        idle_all();
        tick();
        tick();
    endtask

    task test_read;
        idle_all();
        drive_master(2, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        tick();
        s_dat_r = 32'hDEADBEEF;
        s_ack   = 1'b1;
        #1;
        vectors++;
        if (m_dat_r !== 32'hDEADBEEF || m_ack !== 4'b0100 || s_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL read_data: got dat=%h ack=%b we=%b expected deadbeef/0100/0",
                     m_dat_r, m_ack, s_we);
        end
        s_ack = 1'b0;
        s_rty = 1'b1;
        #1;
        vectors++;
        if (m_rty !== 4'b0100 || m_ack !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL read_rty: got rty=%b ack=%b expected 0100/0000", m_rty, m_ack);
        end
        idle_all();
        tick();
        tick();
    endtask

    task test_timeout;
        logic [3:0] exp_err;
        idle_all();
        drive_master(1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
        tick();
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 1; k <= 9; k++) begin
            exp_err = (k == 8) ? 4'b0010 : 4'b0000;
            vectors++;
            if (m_err !== exp_err || s_stb !== (k != 8)) begin
                miscompares++;
                $display("[TB] FAIL timeout_cycle_%0d: got m_err=%b s_stb=%b expected %b/%b",
                         k, m_err, s_stb, exp_err, (k != 8));
            end
            tick();
        end
`else
        exp_err = 4'b0000;
        begin
            int err_seen;
            err_seen = 0;
            for (int k = 0; k < 1000; k++) begin
                if (m_err !== exp_err) err_seen++;
                tick();
            end
            vectors++;
            if (err_seen != 0) begin
                miscompares++;
                $display("[TB] FAIL no_timeout: got %0d err cycles expected 0", err_seen);
            end
        end
`endif
        vectors++;
        if (grant !== 4'b0010 || s_cyc !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL timeout_keeps_grant: got grant=%b s_cyc=%b expected 0010/1", grant, s_cyc);
        end
        idle_all();
        tick();
        vectors++;
        if (grant !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL timeout_release: got %b expected 0000", grant);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        idle_all();
        #3;
        test_reset();
        test_single_request();
        test_round_robin();
        test_back_to_back();
        test_reset_mid_transfer();
        test_read();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
